// File: rtl/fetch_unit.sv
// Program-counter sequencer: sequential, LUT-absolute, relative, call/return
// control flow with a bounded return stack and sticky over/underflow flags.
module fetch_unit #(
    parameter int D         = 10,
    parameter int L         = 5,
    parameter int S         = 4,
    parameter int DONE_ADDR = 381
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      stall,
    input  logic [2:0]                op,
    input  logic                      cond,
    input  logic [L-1:0]              idx,
    input  logic [7:0]                offset,
    input  logic                      lut_we,
    input  logic [L-1:0]              lut_waddr,
    input  logic [D-1:0]              lut_wdata,
    output logic [D-1:0]              prog_ctr,
    output logic                      done,
    output logic [$clog2(S+1)-1:0]    depth,
    output logic                      stk_ovf,
    output logic                      stk_unf
);

    localparam int DW = $clog2(S + 1);
    localparam int SW = (S > 1) ? $clog2(S) : 1;

    localparam logic [2:0] OP_SEQ  = 3'b000;
    localparam logic [2:0] OP_ABS  = 3'b001;
    localparam logic [2:0] OP_REL  = 3'b010;
    localparam logic [2:0] OP_CALL = 3'b011;
    localparam logic [2:0] OP_RET  = 3'b100;

    logic [D-1:0]  pc_q, pc_d;
    logic [DW-1:0] depth_q, depth_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic [D-1:0]  lut_q [2**L];
    logic [D-1:0]  stk_q [S];

    logic          done_s;
    logic          push_s;
    logic [D-1:0]  pc_inc_s;
    logic [D-1:0]  off_ext_s;
    logic [D-1:0]  lut_rd_s;
    logic [SW-1:0] wr_idx_s;
    logic [SW-1:0] top_idx_s;

    assign done_s    = (pc_q == D'(DONE_ADDR));
    assign pc_inc_s  = pc_q + D'(1'b1);
    assign off_ext_s = D'($signed(offset));
    // Combinational read returns the pre-write value when read and write collide.
    assign lut_rd_s  = lut_q[idx];
    assign wr_idx_s  = SW'(depth_q);
    assign top_idx_s = SW'(depth_q - DW'(1'b1));

    // Next-state decode; halt and stall both freeze all control state.
    always_comb begin
        pc_d    = pc_q;
        depth_d = depth_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push_s  = 1'b0;
        if (!done_s && !stall) begin
            case (op)
                OP_SEQ: pc_d = pc_inc_s;
                OP_ABS: pc_d = cond ? lut_rd_s : pc_inc_s;
                OP_REL: pc_d = cond ? (pc_q + off_ext_s) : pc_inc_s;
                OP_CALL: begin
                    pc_d = lut_rd_s;
                    if (depth_q == DW'(S)) begin
                        ovf_d = 1'b1;
                    end else begin
                        push_s  = 1'b1;
                        depth_d = depth_q + DW'(1'b1);
                    end
                end
                OP_RET: begin
                    if (depth_q == {DW{1'b0}}) begin
                        pc_d  = pc_inc_s;
                        unf_d = 1'b1;
                    end else begin
                        pc_d    = stk_q[top_idx_s];
                        depth_d = depth_q - DW'(1'b1);
                    end
                end
                default: pc_d = pc_inc_s;
            endcase
        end else begin
            pc_d    = pc_q;
            depth_d = depth_q;
        end
    end

    // Control state and LUT; LUT writes ignore stall and halt.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= {D{1'b0}};
            depth_q <= {DW{1'b0}};
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            for (int i = 0; i < 2**L; i++) begin
                lut_q[i] <= {D{1'b0}};
            end
        end else begin
            pc_q    <= pc_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            if (lut_we) begin
                lut_q[lut_waddr] <= lut_wdata;
            end
        end
    end

    // Return-stack storage; contents are qualified solely by depth.
    always_ff @(posedge clk) begin
        if (!reset && push_s) begin
            stk_q[wr_idx_s] <= pc_inc_s;
        end
    end

    assign prog_ctr = pc_q;
    assign done     = done_s;
    assign depth    = depth_q;
    assign stk_ovf  = ovf_q;
    assign stk_unf  = unf_q;

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter D, 10, program counter width in bits.
REQ-002 SHALL have parameter L, 5, branch-LUT index width; LUT holds 2^L entries of D bits.
REQ-003 SHALL have parameter S, 4, return-stack depth in entries (S >= 1).
REQ-004 SHALL have parameter DONE_ADDR, 381, program counter value that ends execution.
REQ-005 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have port stall  input  1  hold PC and return stack this cycle.
REQ-008 SHALL have port op  input  3  next-PC mode: 000 SEQ, 001 ABS, 010 REL, 011 CALL, 100 RET; 101-111 behave as SEQ.
REQ-009 SHALL have port cond  input  1  branch condition for ABS and REL.
REQ-010 SHALL have port idx  input  L  LUT index for ABS and CALL.
REQ-011 SHALL have port offset  input  8  signed two's-complement displacement for REL.
REQ-012 SHALL have port lut_we  input  1  LUT write enable.
REQ-013 SHALL have port lut_waddr  input  L  LUT write index.
REQ-014 SHALL have port lut_wdata  input  D  LUT write data.
REQ-015 SHALL have port prog_ctr  output  D  current program counter, registered.
REQ-016 SHALL have port done  output  1  high while prog_ctr == DONE_ADDR, combinational.
REQ-017 SHALL have port depth  output  $clog2(S+1)  current return-stack occupancy, registered.
REQ-018 SHALL have port stk_ovf  output  1  sticky flag: CALL issued with stack full.
REQ-019 SHALL have port stk_unf  output  1  sticky flag: RET issued with stack empty.

Function
REQ-020 Priority per edge SHALL be: reset, then done (halt), then stall, then op.
REQ-021 While done=1, prog_ctr, stack, depth and flags SHALL hold regardless of op and stall.
REQ-022 While stall=1 and done=0, prog_ctr, stack, depth and flags SHALL hold.
REQ-023 SEQ: prog_ctr <= prog_ctr+1, modulo 2^D (wraps 2^D-1 -> 0).
REQ-024 ABS: cond=1 -> prog_ctr <= LUT[idx]; cond=0 -> prog_ctr+1.
REQ-025 REL: cond=1 -> prog_ctr <= prog_ctr + sign-extend(offset) modulo 2^D; cond=0 -> prog_ctr+1.
REQ-026 CALL (unconditional): push prog_ctr+1 (mod 2^D), depth+1, prog_ctr <= LUT[idx].
REQ-027 CALL with depth==S: push discarded, depth unchanged, stk_ovf <= 1, jump to LUT[idx] still taken.
REQ-028 RET (unconditional): prog_ctr <= top entry, pop, depth-1.
REQ-029 RET with depth==0: prog_ctr <= prog_ctr+1, depth stays 0, stk_unf <= 1.
REQ-030 Stack SHALL be LIFO; entries below top are unaffected by push/pop.
REQ-031 LUT write SHALL occur at any edge with lut_we=1 and reset=0, independent of stall and done.
REQ-032 LUT read in the same cycle as a write to the same index SHALL return the old value; new value visible next cycle.
REQ-033 Control-flow latency SHALL be one cycle: op sampled at edge n determines prog_ctr after edge n.
REQ-034 stk_ovf and stk_unf SHALL clear only on reset.

Reset
REQ-035 On reset=1 at an edge: prog_ctr <= 0, depth <= 0, stk_ovf <= 0, stk_unf <= 0, all LUT entries <= 0.
REQ-036 Reset SHALL override any concurrent op, stall or lut_we, including mid CALL/RET sequences.
REQ-037 Stack entry contents after reset are don't-care; only depth governs validity.

Verification
REQ-038 Reset, then 5 cycles op=SEQ -> prog_ctr 0,1,2,3,4,5; depth=0; flags 0.
REQ-039 Write LUT[3]=200; op=ABS idx=3 cond=1 at prog_ctr=5 -> 200; then op=REL offset=-10 cond=1 -> 190; cond=0 -> 191.
REQ-040 D=10, S=4: prog_ctr=10, five CALLs idx=3 (LUT[3]=200) -> depth 4, stk_ovf=1; four RETs -> 201,201,201,11; fifth RET -> 12, stk_unf=1.
REQ-041 prog_ctr=1023, op=SEQ -> 0; prog_ctr=2, REL offset=-3 cond=1 -> 1023.
REQ-042 Drive SEQ to prog_ctr=381 -> done=1; further SEQ/CALL and stall toggling -> prog_ctr stays 381, depth unchanged; reset -> prog_ctr=0, done=0.
REQ-043 stall=1 with op=CALL and lut_we=1 (LUT[7]=50) -> prog_ctr and depth hold; next cycle stall=0, ABS idx=7 cond=1 -> prog_ctr=50.
